clk_rate_select: RTL and testbench

//  Parametrised, glitch-free rate selector driven by one system clock.
//  - NUM_RATES divider rates are generated internally from clk; no external clock is muxed.
//  - Switch inputs are synchronised and debounced before use.
//  - A new rate takes effect only on the current period boundary.
//  - Outputs: a 1-cycle tick enable plus a registered square wave (div_clk) for downstream counters/displays.

---
 rtl/clk_rate_pkg.sv | 29 ++
 rtl/clk_rate_select_sel_debounce.sv | 58 +++++
 rtl/clk_rate_select.sv | 119 +++++++++++
 tb/tb_clk_rate_select.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_rate_pkg.sv
// Shared types and helpers for the clock-rate selector.
package clk_rate_pkg;

    // Default width of each divisor and of the period counter
    localparam int DIV_W_DEF  = 26;

    // Upper bounds used by div_of. The packed divisor list must fit in LIST_MAX_W bits.
    localparam int LIST_MAX_W = 1024;
    localparam int DIV_MAX_W  = 64;

    // Switch FSM encoding
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } sw_state_e;

    // Return entry idx (div_w bits wide) of a packed divisor list; entry 0 sits at the LSBs
    function automatic logic [DIV_MAX_W-1:0] div_of(input logic [LIST_MAX_W-1:0] list,
                                                    input int idx,
                                                    input int div_w);
        logic [LIST_MAX_W-1:0] shifted;
        logic [DIV_MAX_W-1:0]  mask;
        shifted = list >> (idx * div_w);
        mask    = (div_w >= DIV_MAX_W) ? {DIV_MAX_W{1'b1}}
                                       : ((DIV_MAX_W'(1) << div_w) - DIV_MAX_W'(1));
        return shifted[DIV_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/clk_rate_select_sel_debounce.sv
// Two-flop synchroniser plus stability counter for the rate-select switches.
// stable_sel follows sel_raw once the synchronised value has held for DEBOUNCE_CYC samples.
module sel_debounce #(
    parameter int               SEL_W        = 2,
    parameter int               DEBOUNCE_CYC = 16,
    parameter logic [SEL_W-1:0] RESET_SEL    = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_raw,
    output logic [SEL_W-1:0] stable_sel
);

    localparam int             CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SEL_W-1:0] sync1_q, sync1_d;
    logic [SEL_W-1:0] sync2_q, sync2_d;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [SEL_W-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchronise, track the candidate value and load it once it has been stable long enough
    always_comb begin
        sync1_d = sel_raw;
        sync2_d = sync1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Looking at the next count lets a fresh value land exactly 2 + DEBOUNCE_CYC cycles after sel_raw moves
        stable_d = (cnt_d == CNT_MAX) ? cand_d : stable_q;
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= RESET_SEL;
            sync2_q  <= RESET_SEL;
            cand_q   <= RESET_SEL;
            stable_q <= RESET_SEL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_sel = stable_q;

endmodule

// File: rtl/clk_rate_select.sv
// Glitch-free rate selector: divides clk by one of NUM_RATES divisors and switches
// between them only on a period boundary, producing a tick enable and a square wave.
module clk_rate_select
    import clk_rate_pkg::*;
#(
    parameter int                         NUM_RATES    = 3,
    parameter int                         SEL_W        = 2,
    parameter int                         DIV_W        = DIV_W_DEF,
    parameter logic [NUM_RATES*DIV_W-1:0] DIV_LIST     = {26'd8, 26'd4, 26'd2},
    parameter int                         DEBOUNCE_CYC = 16,
    parameter int                         RESET_RATE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel_raw,
    output logic             tick,
    output logic             div_clk,
    output logic [SEL_W-1:0] rate_idx,
    output logic             switch_pending
);

    localparam logic [LIST_MAX_W-1:0] LIST_PAD    = LIST_MAX_W'(DIV_LIST);
    localparam logic [SEL_W:0]        NUM_RATES_W = (SEL_W + 1)'(NUM_RATES);
    localparam logic [SEL_W-1:0]      RESET_SEL   = SEL_W'(RESET_RATE);

    logic [SEL_W-1:0] stable_sel;
    logic             sel_valid;
    logic [DIV_W-1:0] div_raw, div_eff;
    logic             at_end;
    logic             do_switch;

    sw_state_e        state_q, state_d;
    logic [SEL_W-1:0] req_q, req_d;
    logic [SEL_W-1:0] rate_idx_q, rate_idx_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             div_clk_q, div_clk_d;

    sel_debounce #(
        .SEL_W        (SEL_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .RESET_SEL    (RESET_SEL)
    ) u_sel_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_raw    (sel_raw),
        .stable_sel (stable_sel)
    );

    // Divisor of the active rate (0 behaves as 1) and period-boundary detect
    always_comb begin
        sel_valid = ({1'b0, stable_sel} < NUM_RATES_W);
        div_raw   = DIV_W'(div_of(LIST_PAD, int'(rate_idx_q), DIV_W));
        div_eff   = (div_raw == '0) ? DIV_W'(1) : div_raw;
        at_end    = (cnt_q == div_eff - DIV_W'(1));
    end

    // Switch FSM next state: track the newest valid request, cancel on return, commit on boundary
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        do_switch = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_valid && (stable_sel != rate_idx_q)) begin
                    state_d = S_PENDING;
                    req_d   = stable_sel;
                end
            end
            S_PENDING: begin
                if (sel_valid && (stable_sel == rate_idx_q)) begin
                    state_d = S_IDLE;
                end else begin
                    if (sel_valid) begin
                        req_d = stable_sel;
                    end
                    if (at_end) begin
                        do_switch = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Switch FSM outputs and period datapath; the boundary tick of the old rate always fires
    always_comb begin
        switch_pending = (state_q == S_PENDING);
        rate_idx_d     = do_switch ? req_d : rate_idx_q;
        cnt_d          = at_end ? '0 : cnt_q + DIV_W'(1);
        tick_d         = at_end;
        div_clk_d      = div_clk_q ^ at_end;
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_q      <= RESET_SEL;
            rate_idx_q <= RESET_SEL;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            div_clk_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            rate_idx_q <= rate_idx_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            div_clk_q  <= div_clk_d;
        end
    end

    assign tick     = tick_q;
    assign div_clk  = div_clk_q;
    assign rate_idx = rate_idx_q;

endmodule

// File: tb/tb_clk_rate_select.sv
// Randomised and directed bench for clk_rate_select against a cycle-level behavioural model.
module tb_clk_rate_select;

    localparam int NUM_RATES  = 3;
    localparam int SEL_W      = 2;
    localparam int DIV_W      = 26;
    localparam int DEB        = 4;
    localparam int RESET_RATE = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SEL_W-1:0] sel_raw = '0;
    logic             tick;
    logic             div_clk;
    logic [SEL_W-1:0] rate_idx;
    logic             switch_pending;

    always #5 clk = ~clk;

    clk_rate_select #(
        .NUM_RATES    (NUM_RATES),
        .SEL_W        (SEL_W),
        .DIV_W        (DIV_W),
        .DIV_LIST     ({26'd8, 26'd4, 26'd2}),
        .DEBOUNCE_CYC (DEB),
        .RESET_RATE   (RESET_RATE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel_raw        (sel_raw),
        .tick           (tick),
        .div_clk        (div_clk),
        .rate_idx       (rate_idx),
        .switch_pending (switch_pending)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: rate r divides by DIVS[r]
    int DIVS [NUM_RATES] = '{2, 4, 8};
    int m_sp1, m_sp2;
    int hist[$];
    int m_stable, m_rate, m_req, m_phase;
    bit m_pend, m_tick, m_div;

    function automatic void model_reset();
        m_sp1 = RESET_RATE;
        m_sp2 = RESET_RATE;
        hist.delete();
        for (int i = 0; i < DEB; i++) hist.push_back(RESET_RATE);
        m_stable = RESET_RATE;
        m_rate   = RESET_RATE;
        m_req    = RESET_RATE;
        m_phase  = 0;
        m_pend   = 1'b0;
        m_tick   = 1'b0;
        m_div    = 1'b0;
    endfunction

    function automatic void model_edge(input int raw);
        int  s;
        int  d;
        bit  fin;
        bit  valid;
        bit  same;
        s     = m_sp2;
        m_sp2 = m_sp1;
        m_sp1 = raw;
        d     = DIVS[m_rate];
        fin   = (m_phase == d - 1);
        valid = (m_stable < NUM_RATES);
        if (m_pend) begin
            if (valid && m_stable == m_rate) begin
                m_pend = 1'b0;
            end else begin
                if (valid) m_req = m_stable;
                if (fin) begin
                    m_rate = m_req;
                    m_pend = 1'b0;
                end
            end
        end else if (valid && m_stable != m_rate) begin
            m_pend = 1'b1;
            m_req  = m_stable;
        end
        m_tick  = fin;
        if (fin) m_div = !m_div;
        m_phase = fin ? 0 : m_phase + 1;
        // A synchronised value is accepted after DEB identical consecutive samples
        hist.push_back(s);
        if (hist.size() > DEB) void'(hist.pop_front());
        same = 1'b1;
        foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
        if (same) m_stable = hist[0];
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(int'(sel_raw));
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("div_clk", 32'(div_clk), 32'(m_div));
        chk("rate_idx", 32'(rate_idx), 32'(m_rate));
        chk("pending", 32'(switch_pending), 32'(m_pend));
    endtask

    task automatic hold(input int sel, input int n);
        sel_raw = SEL_W'(sel);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = tick;
        end
        chk("tick_seen", 32'(got), 32'd1);
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release away from the clock edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_div_clk", 32'(div_clk), 32'd0);
        chk("rst_rate_idx", 32'(rate_idx), 32'(RESET_RATE));
        chk("rst_pending", 32'(switch_pending), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit got;
        model_reset();
        #2;
        chk("init_tick", 32'(tick), 32'd0);
        chk("init_div_clk", 32'(div_clk), 32'd0);
        chk("init_rate_idx", 32'(rate_idx), 32'(RESET_RATE));
        chk("init_pending", 32'(switch_pending), 32'd0);
        #10;
        rst_n = 1'b1;

        // 1: default rate, tick every 2 cycles
        hold(0, 12);
        chk("t1_rate", 32'(rate_idx), 32'd0);

        // 2: switch to the slowest rate
        hold(2, 30);
        chk("t2_rate", 32'(rate_idx), 32'd2);
        hold(2, 20);

        // 3: bouncing switch settles on 1
        hold(1, 1);
        for (int i = 0; i < 10; i++) begin
            hold(0, 1);
            hold(1, 1);
        end
        chk("t3_no_change", 32'(rate_idx), 32'd2);
        hold(1, 20);
        chk("t3_rate", 32'(rate_idx), 32'd1);

        // 4: retarget and cancel while a request is pending, across period phases
        hold(2, 24);
        hold(1, 7);
        hold(0, 14);
        hold(2, 24);
        for (int off = 0; off < 8; off++) begin
            wait_tick();
            hold(2, off);
            hold(1, 4);
            hold(2, 14);
        end

        // 5: invalid select is ignored
        hold(1, 24);
        chk("t5_rate_before", 32'(rate_idx), 32'd1);
        hold(3, 30);
        chk("t5_rate_after", 32'(rate_idx), 32'd1);
        chk("t5_pending", 32'(switch_pending), 32'd0);

        // 6: reset while a request is pending
        sel_raw = 2'd2;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = switch_pending;
        end
        chk("t6_pend_seen", 32'(got), 32'd1);
        do_reset();
        step();
        chk("t6_rate", 32'(rate_idx), 32'd0);

        // Random segments, including invalid selects, short glitches and occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            hold(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
